// File: rtl/d_branch_seq_if.sv
// Branch-sequencer bus: D-stage operands/handshake in, redirect/link/flush/statistics out.
interface d_branch_seq_if #(
   parameter int unsigned CNT_W = 16
);
   logic              br_valid;
   logic [2:0]        cmp_op;
   logic              rs_ready;
   logic              rt_ready;
   logic [31:0]       rs_data;
   logic [31:0]       rt_data;
   logic [31:0]       pc_d;
   logic [31:0]       offset;
   logic              stall;
   logic              redirect;
   logic [31:0]       target;
   logic              flush_slot;
   logic              link_we;
   logic [31:0]       link_data;
   logic [CNT_W-1:0]  br_total;
   logic [CNT_W-1:0]  br_taken;
   logic              err_timeout;

   // Pipeline side: presents the D-stage branch and consumes the sequencer results.
   modport master (
      output br_valid, cmp_op, rs_ready, rt_ready, rs_data, rt_data, pc_d, offset,
      input  stall, redirect, target, flush_slot, link_we, link_data,
             br_total, br_taken, err_timeout
   );

   // Sequencer side.
   modport slave (
      input  br_valid, cmp_op, rs_ready, rt_ready, rs_data, rt_data, pc_d, offset,
      output stall, redirect, target, flush_slot, link_we, link_data,
             br_total, br_taken, err_timeout
   );
endinterface

// File: rtl/d_branch_seq.sv
// D-stage branch sequencer: waits for forwarded operands, resolves beq/bltzal,
// then issues registered redirect / link-write / delay-slot flush pulses.
module d_branch_seq #(
   parameter int unsigned MAX_STALL = 3,
   parameter int unsigned CNT_W     = 16
) (
   input  logic          clk,
   input  logic          reset,
   d_branch_seq_if.slave bus
);

   localparam int unsigned SC_W      = $clog2(MAX_STALL + 1);
   localparam logic [2:0]  OP_BEQ    = 3'd1;
   localparam logic [2:0]  OP_BLTZAL = 3'd2;
   localparam logic [31:0] PC_INC4   = 32'd4;
   localparam logic [31:0] PC_INC8   = 32'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SLOT = 2'd2
   } state_t;

   state_t           state_q;
   logic [SC_W-1:0]  stall_cnt_q;
   logic             redirect_q;
   logic             flush_slot_q;
   logic             link_we_q;
   logic             err_timeout_q;
   logic [31:0]      target_q;
   logic [31:0]      link_data_q;
   logic [CNT_W-1:0] br_total_q;
   logic [CNT_W-1:0] br_taken_q;

   logic             is_beq;
   logic             is_bltzal;
   logic             need;
   logic             ready;
   logic             taken;
   logic             cmp_window;
   logic             resolve;
   logic             stall_c;
   logic [SC_W-1:0]  stall_cnt_inc;
   logic             hit_max;

   // Operand readiness, branch condition and stall decision for the current cycle.
   always_comb begin
      is_beq        = 1'b0;
      is_bltzal     = 1'b0;
      need          = 1'b0;
      ready         = 1'b0;
      taken         = 1'b0;
      cmp_window    = 1'b0;
      resolve       = 1'b0;
      stall_c       = 1'b0;
      stall_cnt_inc = SC_W'(1);
      hit_max       = 1'b0;

      is_beq     = (bus.cmp_op == OP_BEQ);
      is_bltzal  = (bus.cmp_op == OP_BLTZAL);
      need       = bus.br_valid && (is_beq || is_bltzal);
      // bltzal only reads rs, so rt readiness is irrelevant for it
      ready      = bus.rs_ready && (bus.rt_ready || is_bltzal);
      taken      = is_bltzal ? bus.rs_data[31] : (bus.rs_data == bus.rt_data);
      // The delay-slot cycle never compares or stalls; a branch there is illegal
      cmp_window = (state_q != S_SLOT);
      resolve    = cmp_window && need && ready;
      stall_c    = cmp_window && need && !ready;

      // First stall cycle counts as 1; further cycles saturate at MAX_STALL
      if (state_q == S_WAIT) begin
         if (stall_cnt_q == SC_W'(MAX_STALL)) begin
            stall_cnt_inc = stall_cnt_q;
         end else begin
            stall_cnt_inc = stall_cnt_q + SC_W'(1);
         end
      end
      hit_max = stall_c && (stall_cnt_inc == SC_W'(MAX_STALL));
   end

   // Sequencer state, resolve capture, one-cycle pulses and saturating statistics.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         stall_cnt_q   <= '0;
         redirect_q    <= 1'b0;
         flush_slot_q  <= 1'b0;
         link_we_q     <= 1'b0;
         err_timeout_q <= 1'b0;
         target_q      <= '0;
         link_data_q   <= '0;
         br_total_q    <= '0;
         br_taken_q    <= '0;
      end else begin
         // Pulses are high only in the cycle right after a resolve
         redirect_q   <= 1'b0;
         flush_slot_q <= 1'b0;
         link_we_q    <= 1'b0;

         if (hit_max) begin
            err_timeout_q <= 1'b1;
         end

         if (resolve) begin
            target_q     <= bus.pc_d + PC_INC4 + bus.offset;
            link_data_q  <= bus.pc_d + PC_INC8;
            redirect_q   <= taken;
            link_we_q    <= is_bltzal;
            flush_slot_q <= is_bltzal && !taken;
            if (br_total_q != {CNT_W{1'b1}}) begin
               br_total_q <= br_total_q + CNT_W'(1);
            end
            if (taken && (br_taken_q != {CNT_W{1'b1}})) begin
               br_taken_q <= br_taken_q + CNT_W'(1);
            end
         end

         case (state_q)
            S_IDLE: begin
               if (resolve) begin
                  state_q <= S_SLOT;
               end else if (stall_c) begin
                  state_q     <= S_WAIT;
                  stall_cnt_q <= stall_cnt_inc;
               end
            end
            S_WAIT: begin
               if (resolve) begin
                  state_q     <= S_SLOT;
                  stall_cnt_q <= '0;
               end else if (stall_c) begin
                  stall_cnt_q <= stall_cnt_inc;
               end else begin
                  // Branch killed upstream: abandon it without any side effect
                  state_q     <= S_IDLE;
                  stall_cnt_q <= '0;
               end
            end
            S_SLOT: begin
               state_q     <= S_IDLE;
               stall_cnt_q <= '0;
            end
            default: begin
               state_q     <= S_IDLE;
               stall_cnt_q <= '0;
            end
         endcase
      end
   end

   // Output mapping onto the bus.
   assign bus.stall       = stall_c;
   assign bus.redirect    = redirect_q;
   assign bus.target      = target_q;
   assign bus.flush_slot  = flush_slot_q;
   assign bus.link_we     = link_we_q;
   assign bus.link_data   = link_data_q;
   assign bus.br_total    = br_total_q;
   assign bus.br_taken    = br_taken_q;
   assign bus.err_timeout = err_timeout_q;

endmodule

// File: tb/tb_d_branch_seq.sv
// Directed bench for d_branch_seq: per-cycle vector table plus reset/saturation sequences.
module tb_d_branch_seq;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   d_branch_seq_if #(.CNT_W(4)) bus ();

   d_branch_seq #(
      .MAX_STALL (3),
      .CNT_W     (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        bv;
      logic [2:0]  op;
      logic        rsr;
      logic        rtr;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [31:0] pc;
      logic [31:0] off;
      logic        e_stall;
      logic        e_redir;
      logic        e_flush;
      logic        e_lwe;
      logic [31:0] e_tgt;
      logic [31:0] e_lnk;
      logic [3:0]  e_tot;
      logic [3:0]  e_tk;
      logic        e_err;
   } vec_t;

   localparam int NV = 28;
   vec_t vecs [NV];

   function automatic vec_t mkv(
      input logic bv, input logic [2:0] op, input logic rsr, input logic rtr,
      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] pc, input logic [31:0] off,
      input logic st, input logic rd, input logic fl, input logic lw,
      input logic [31:0] tgt, input logic [31:0] lnk,
      input logic [3:0] tot, input logic [3:0] tk, input logic err);
      vec_t v;
      v.bv = bv; v.op = op; v.rsr = rsr; v.rtr = rtr;
      v.rs = rs; v.rt = rt; v.pc = pc; v.off = off;
      v.e_stall = st; v.e_redir = rd; v.e_flush = fl; v.e_lwe = lw;
      v.e_tgt = tgt; v.e_lnk = lnk; v.e_tot = tot; v.e_tk = tk; v.e_err = err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input logic bv, input logic [2:0] op, input logic rsr, input logic rtr,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] pc, input logic [31:0] off);
      bus.br_valid = bv;
      bus.cmp_op   = op;
      bus.rs_ready = rsr;
      bus.rt_ready = rtr;
      bus.rs_data  = rs;
      bus.rt_data  = rt;
      bus.pc_d     = pc;
      bus.offset   = off;
   endtask

   task automatic drive_idle();
      drive(1'b0, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;

      //       bv  op   rsr  rtr  rs            rt          pc          off           st rd fl lw tgt           lnk           tot tk err
      vecs[0]  = mkv(1, 3'd1, 1, 1, 32'h1234,     32'h1234,   32'h3000,   32'h10,       0, 0, 0, 0, 32'h0,      32'h0,      0, 0, 0);
      vecs[1]  = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 1, 0, 0, 32'h3014,   32'h3008,   1, 1, 0);
      vecs[2]  = mkv(1, 3'd2, 1, 0, 32'h80000000, 32'h0,      32'h3000,   32'h10,       0, 0, 0, 0, 32'h3014,   32'h3008,   1, 1, 0);
      vecs[3]  = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 1, 0, 1, 32'h3014,   32'h3008,   2, 2, 0);
      vecs[4]  = mkv(1, 3'd2, 1, 0, 32'h5,        32'h0,      32'h4000,   32'h20,       0, 0, 0, 0, 32'h3014,   32'h3008,   2, 2, 0);
      vecs[5]  = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 1, 1, 32'h4024,   32'h4008,   3, 2, 0);
      vecs[6]  = mkv(1, 3'd1, 1, 0, 32'h7,        32'h7,      32'h5000,   32'hFFFFFFF0, 1, 0, 0, 0, 32'h4024,   32'h4008,   3, 2, 0);
      vecs[7]  = mkv(1, 3'd1, 1, 0, 32'h7,        32'h7,      32'h5000,   32'hFFFFFFF0, 1, 0, 0, 0, 32'h4024,   32'h4008,   3, 2, 0);
      vecs[8]  = mkv(1, 3'd1, 1, 1, 32'h7,        32'h7,      32'h5000,   32'hFFFFFFF0, 0, 0, 0, 0, 32'h4024,   32'h4008,   3, 2, 0);
      vecs[9]  = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 1, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 0);
      vecs[10] = mkv(1, 3'd1, 0, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        1, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 0);
      vecs[11] = mkv(1, 3'd1, 0, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        1, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 0);
      vecs[12] = mkv(1, 3'd1, 0, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        1, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 0);
      vecs[13] = mkv(1, 3'd1, 0, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        1, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 1);
      vecs[14] = mkv(1, 3'd1, 0, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        1, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 1);
      vecs[15] = mkv(1, 3'd1, 1, 1, 32'h1,        32'h2,      32'h6000,   32'h8,        0, 0, 0, 0, 32'h4FF4,   32'h5008,   4, 3, 1);
      vecs[16] = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 0, 0, 32'h600C,   32'h6008,   5, 3, 1);
      vecs[17] = mkv(1, 3'd2, 0, 0, 32'h80000000, 32'h0,      32'h7000,   32'h40,       1, 0, 0, 0, 32'h600C,   32'h6008,   5, 3, 1);
      vecs[18] = mkv(0, 3'd2, 0, 0, 32'h80000000, 32'h0,      32'h7000,   32'h40,       0, 0, 0, 0, 32'h600C,   32'h6008,   5, 3, 1);
      vecs[19] = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 0, 0, 32'h600C,   32'h6008,   5, 3, 1);
      vecs[20] = mkv(1, 3'd1, 1, 1, 32'h9,        32'h9,      32'h8000,   32'h100,      0, 0, 0, 0, 32'h600C,   32'h6008,   5, 3, 1);
      vecs[21] = mkv(1, 3'd1, 1, 1, 32'h9,        32'h9,      32'h9000,   32'h0,        0, 1, 0, 0, 32'h8104,   32'h8008,   6, 4, 1);
      vecs[22] = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 0, 0, 32'h8104,   32'h8008,   6, 4, 1);
      vecs[23] = mkv(1, 3'd1, 1, 1, 32'h9,        32'h9,      32'h8000,   32'h100,      0, 0, 0, 0, 32'h8104,   32'h8008,   6, 4, 1);
      vecs[24] = mkv(1, 3'd1, 0, 1, 32'h9,        32'h9,      32'h8000,   32'h100,      0, 1, 0, 0, 32'h8104,   32'h8008,   7, 5, 1);
      vecs[25] = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 0, 0, 32'h8104,   32'h8008,   7, 5, 1);
      vecs[26] = mkv(1, 3'd5, 1, 1, 32'h9,        32'h9,      32'hA000,   32'h0,        0, 0, 0, 0, 32'h8104,   32'h8008,   7, 5, 1);
      vecs[27] = mkv(0, 3'd0, 0, 0, 32'h0,        32'h0,      32'h0,      32'h0,        0, 0, 0, 0, 32'h8104,   32'h8008,   7, 5, 1);

      // Reset state
      reset = 1'b0;
      drive_idle();
      @(negedge clk);
      chk("reset stall",       32'(bus.stall),       32'h0);
      chk("reset redirect",    32'(bus.redirect),    32'h0);
      chk("reset flush_slot",  32'(bus.flush_slot),  32'h0);
      chk("reset link_we",     32'(bus.link_we),     32'h0);
      chk("reset target",      bus.target,           32'h0);
      chk("reset link_data",   bus.link_data,        32'h0);
      chk("reset br_total",    32'(bus.br_total),    32'h0);
      chk("reset br_taken",    32'(bus.br_taken),    32'h0);
      chk("reset err_timeout", 32'(bus.err_timeout), 32'h0);
      reset = 1'b1;

      // Per-cycle vector table: inputs applied at negedge, outputs sampled 2 time units later
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i].bv, vecs[i].op, vecs[i].rsr, vecs[i].rtr,
               vecs[i].rs, vecs[i].rt, vecs[i].pc, vecs[i].off);
         #2;
         chk($sformatf("row%0d stall", i),       32'(bus.stall),       32'(vecs[i].e_stall));
         chk($sformatf("row%0d redirect", i),    32'(bus.redirect),    32'(vecs[i].e_redir));
         chk($sformatf("row%0d flush_slot", i),  32'(bus.flush_slot),  32'(vecs[i].e_flush));
         chk($sformatf("row%0d link_we", i),     32'(bus.link_we),     32'(vecs[i].e_lwe));
         chk($sformatf("row%0d target", i),      bus.target,           vecs[i].e_tgt);
         chk($sformatf("row%0d link_data", i),   bus.link_data,        vecs[i].e_lnk);
         chk($sformatf("row%0d br_total", i),    32'(bus.br_total),    32'(vecs[i].e_tot));
         chk($sformatf("row%0d br_taken", i),    32'(bus.br_taken),    32'(vecs[i].e_tk));
         chk($sformatf("row%0d err_timeout", i), 32'(bus.err_timeout), 32'(vecs[i].e_err));
      end

      // Asynchronous reset during the SLOT cycle of a not-taken bltzal
      @(negedge clk);
      drive(1'b1, 3'd2, 1'b1, 1'b0, 32'h5, 32'h0, 32'hB000, 32'h0);
      @(negedge clk);
      drive_idle();
      #2;
      chk("slot flush_slot pre-reset", 32'(bus.flush_slot), 32'h1);
      chk("slot link_we pre-reset",    32'(bus.link_we),    32'h1);
      #1;
      reset = 1'b0;
      #1;
      chk("async reset redirect",    32'(bus.redirect),    32'h0);
      chk("async reset flush_slot",  32'(bus.flush_slot),  32'h0);
      chk("async reset link_we",     32'(bus.link_we),     32'h0);
      chk("async reset br_total",    32'(bus.br_total),    32'h0);
      chk("async reset br_taken",    32'(bus.br_taken),    32'h0);
      chk("async reset err_timeout", 32'(bus.err_timeout), 32'h0);
      chk("async reset target",      bus.target,           32'h0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #2;
      chk("post-reset redirect",   32'(bus.redirect),   32'h0);
      chk("post-reset flush_slot", 32'(bus.flush_slot), 32'h0);
      chk("post-reset link_we",    32'(bus.link_we),    32'h0);
      chk("post-reset br_total",   32'(bus.br_total),   32'h0);

      // Counter saturation with 4-bit counters: 16 taken beqs
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         drive(1'b1, 3'd1, 1'b1, 1'b1, 32'hAA, 32'hAA, 32'hC000, 32'h4);
         @(negedge clk);
         drive_idle();
         #2;
         chk($sformatf("sat%0d redirect", k), 32'(bus.redirect), 32'h1);
         chk($sformatf("sat%0d br_total", k), 32'(bus.br_total), (k > 15) ? 32'd15 : 32'(k));
         chk($sformatf("sat%0d br_taken", k), 32'(bus.br_taken), (k > 15) ? 32'd15 : 32'(k));
      end
      chk("sat target", bus.target, 32'hC008);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
